// File: rtl/rr_arbiter_6.sv
// rr_arbiter_6: round-robin arbiter that shares one resource among N requesters.
// A grant is held until the owner drops its request, the resource pulses done,
// or the hold counter reaches MAX_HOLD. Every release is followed by one dead
// cycle (GAP), so the decoder driven by gnt_idx never switches owners on
// consecutive cycles.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      per-requester level request, held while wanting/owning
//   done     one-cycle completion pulse from the resource
//   gnt_vld  a grant is active
//   gnt_idx  index of current/last owner (decoder select)
//   gnt      one-hot grant, zero when gnt_vld=0
//   timeout  one-cycle pulse on a forced release by MAX_HOLD
//   busy     high in OWN and GAP
module rr_arbiter_6 #(
  parameter int unsigned N        = 6,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt,
  output logic             timeout,
  output logic             busy
);

  localparam int unsigned CAND_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_gnt_vld;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [N-1:0]       r_gnt;
  logic               r_timeout;
  logic               r_busy;
  logic [IDX_W-1:0]   r_ptr;
  logic [HOLD_W-1:0]  r_hold_cnt;

  state_t             w_nxt_state;
  logic               w_nxt_gnt_vld;
  logic [IDX_W-1:0]   w_nxt_gnt_idx;
  logic [N-1:0]       w_nxt_gnt;
  logic               w_nxt_timeout;
  logic               w_nxt_busy;
  logic [IDX_W-1:0]   w_nxt_ptr;
  logic [HOLD_W-1:0]  w_nxt_hold_cnt;

  logic               w_found;
  logic [IDX_W-1:0]   w_winner;
  logic [N-1:0]       w_winner_oh;
  logic [CAND_W-1:0]  w_cand;
  logic               w_own_req;
  logic               w_at_max;
  logic               w_release;
  logic               w_hold_to;
  logic [IDX_W-1:0]   w_ptr_inc;

  // Search req starting at r_ptr, wrapping modulo N; first set bit wins.
  always_comb begin
    w_found     = 1'b0;
    w_winner    = '0;
    w_winner_oh = '0;
    w_cand      = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_cand = {1'b0, r_ptr} + CAND_W'(i);
      if (w_cand >= CAND_W'(N)) begin
        w_cand = w_cand - CAND_W'(N);
      end
      for (int j = 0; j < int'(N); j++) begin
        if (!w_found && req[j] && (w_cand == CAND_W'(j))) begin
          w_found  = 1'b1;
          w_winner = IDX_W'(j);
        end
      end
    end
    for (int j = 0; j < int'(N); j++) begin
      w_winner_oh[j] = (IDX_W'(j) == w_winner);
    end
  end

  // Release conditions for the current owner; r_gnt is one-hot on the owner.
  always_comb begin
    w_own_req = |(req & r_gnt);
    w_at_max  = (r_hold_cnt == HOLD_W'(MAX_HOLD));
    w_release = !w_own_req || done || w_at_max;
    // Timeout only when the hold limit is the sole cause of release.
    w_hold_to = w_at_max && w_own_req && !done;
    w_ptr_inc = (r_gnt_idx == IDX_W'(N - 1)) ? '0 : r_gnt_idx + IDX_W'(1);
  end

  // Next-state and next-output logic.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_gnt_vld  = r_gnt_vld;
    w_nxt_gnt_idx  = r_gnt_idx;
    w_nxt_gnt      = r_gnt;
    w_nxt_timeout  = 1'b0;
    w_nxt_ptr      = r_ptr;
    w_nxt_hold_cnt = r_hold_cnt;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_nxt_state    = ST_OWN;
          w_nxt_gnt_vld  = 1'b1;
          w_nxt_gnt_idx  = w_winner;
          w_nxt_gnt      = w_winner_oh;
          w_nxt_hold_cnt = HOLD_W'(1);
        end
      end
      ST_OWN: begin
        if (w_release) begin
          w_nxt_state    = ST_GAP;
          w_nxt_gnt_vld  = 1'b0;
          w_nxt_gnt      = '0;
          w_nxt_ptr      = w_ptr_inc;
          w_nxt_timeout  = w_hold_to;
          w_nxt_hold_cnt = '0;
        end else if (!w_at_max) begin
          w_nxt_hold_cnt = r_hold_cnt + HOLD_W'(1);
        end
      end
      ST_GAP: begin
        w_nxt_state = ST_IDLE;
      end
      default: begin
        w_nxt_state   = ST_IDLE;
        w_nxt_gnt_vld = 1'b0;
        w_nxt_gnt     = '0;
      end
    endcase

    w_nxt_busy = (w_nxt_state == ST_OWN) || (w_nxt_state == ST_GAP);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt_vld  <= 1'b0;
      r_gnt_idx  <= '0;
      r_gnt      <= '0;
      r_timeout  <= 1'b0;
      r_busy     <= 1'b0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_gnt_vld  <= w_nxt_gnt_vld;
      r_gnt_idx  <= w_nxt_gnt_idx;
      r_gnt      <= w_nxt_gnt;
      r_timeout  <= w_nxt_timeout;
      r_busy     <= w_nxt_busy;
      r_ptr      <= w_nxt_ptr;
      r_hold_cnt <= w_nxt_hold_cnt;
    end
  end

  assign gnt_vld = r_gnt_vld;
  assign gnt_idx = r_gnt_idx;
  assign gnt     = r_gnt;
  assign timeout = r_timeout;
  assign busy    = r_busy;

endmodule

// File: tb/tb_rr_arbiter_6.sv
// Testbench for rr_arbiter_6: directed scenarios plus randomized traffic,
// checked every cycle against an integer-level reference model.
module tb_rr_arbiter_6;

  localparam int unsigned N        = 6;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned MAX_HOLD = 16;
  localparam int unsigned HOLD_W   = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic             done;
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  logic [N-1:0]     gnt;
  logic             timeout;
  logic             busy;

  always #5 clk = ~clk;

  rr_arbiter_6 #(
    .N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt_vld(gnt_vld), .gnt_idx(gnt_idx), .gnt(gnt),
    .timeout(timeout), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner (-1 when none), dead-cycle flag, pointer, hold count.
  int m_owner;
  int m_last;
  int m_ptr;
  int m_hold;
  bit m_gap;
  bit m_to;

  // Observed grant history and timeout pulses for directed scenarios.
  int grants[$];
  bit prev_vld;
  int n_to;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_gap   = 1'b0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic d);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner] || d || m_hold == int'(MAX_HOLD)) begin
        m_to    = r[m_owner] && !d;
        m_ptr   = (m_owner + 1) % int'(N);
        m_owner = -1;
        m_gap   = 1'b1;
      end else begin
        m_hold = (m_hold + 1 > int'(MAX_HOLD)) ? int'(MAX_HOLD) : m_hold + 1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % int'(N)]) begin
          m_owner = (m_ptr + k) % int'(N);
          m_last  = m_owner;
          m_hold  = 1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string where);
    logic [N-1:0] e_gnt;
    e_gnt = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    check_eq({where, ".gnt_vld"}, 32'(gnt_vld), 32'(m_owner >= 0));
    check_eq({where, ".gnt_idx"}, 32'(gnt_idx), 32'(m_last));
    check_eq({where, ".gnt"},     32'(gnt),     32'(e_gnt));
    check_eq({where, ".timeout"}, 32'(timeout), 32'(m_to));
    check_eq({where, ".busy"},    32'(busy),    32'((m_owner >= 0) || m_gap));
  endtask

  // Called at posedge+1: drive inputs, take one edge, step model, compare.
  task automatic cycle(input string where, input logic [N-1:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    check_outputs(where);
    if (gnt_vld && !prev_vld) grants.push_back(int'(gnt_idx));
    prev_vld = gnt_vld;
    if (timeout) n_to++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    grants.delete();
    prev_vld = 1'b0;
    n_to     = 0;
  endtask

  function automatic int grant_at(input int i);
    return (i < grants.size()) ? grants[i] : 99;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r;
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    @(posedge clk);
    #1;

    // 1: single requester, done three cycles after grant, then regrant.
    do_reset();
    cycle("t1", 6'b000100, 1'b0);
    cycle("t1", 6'b000100, 1'b0);
    cycle("t1", 6'b000100, 1'b0);
    cycle("t1", 6'b000100, 1'b1);
    repeat (4) cycle("t1", 6'b000100, 1'b0);
    check_eq("t1.first_grant", 32'(grant_at(0)), 32'd2);
    check_eq("t1.regrant", 32'(grant_at(1)), 32'd2);

    // 2: all requesting, done always high -> strict rotation.
    do_reset();
    repeat (20) cycle("t2", 6'b111111, 1'b1);
    for (int i = 0; i < 7; i++) begin
      check_eq($sformatf("t2.order%0d", i), 32'(grant_at(i)), 32'(i % 6));
    end

    // 3: two requesters, no done -> forced releases by hold limit.
    do_reset();
    repeat (40) cycle("t3", 6'b100001, 1'b0);
    check_eq("t3.g0", 32'(grant_at(0)), 32'd0);
    check_eq("t3.g1", 32'(grant_at(1)), 32'd5);
    check_eq("t3.g2", 32'(grant_at(2)), 32'd0);
    check_eq("t3.timeouts", 32'(n_to), 32'd2);

    // 4: owner 3 drops its request while 1 waits.
    do_reset();
    cycle("t4", 6'b001000, 1'b0);
    cycle("t4", 6'b001010, 1'b0);
    cycle("t4", 6'b001010, 1'b0);
    repeat (6) cycle("t4", 6'b000010, 1'b0);
    check_eq("t4.g0", 32'(grant_at(0)), 32'd3);
    check_eq("t4.g1", 32'(grant_at(1)), 32'd1);
    check_eq("t4.timeouts", 32'(n_to), 32'd0);

    // 5: asynchronous reset while requester 4 owns.
    do_reset();
    repeat (3) cycle("t5", 6'b010000, 1'b0);
    check_eq("t5.owner", 32'(grant_at(0)), 32'd4);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("t5.async");
    req = 6'b110000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    grants.delete();
    prev_vld = 1'b0;
    repeat (4) cycle("t5", 6'b110000, 1'b0);
    check_eq("t5.after_reset", 32'(grant_at(0)), 32'd4);

    // 6: done in IDLE and in GAP with no requests.
    do_reset();
    cycle("t6", 6'b000000, 1'b1);
    cycle("t6", 6'b000001, 1'b0);
    cycle("t6", 6'b000000, 1'b0);
    cycle("t6", 6'b000000, 1'b1);
    cycle("t6", 6'b000000, 1'b1);
    cycle("t6", 6'b000000, 1'b0);

    // Random traffic.
    do_reset();
    r = 6'($urandom());
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) begin
        int b;
        b = int'($urandom_range(N - 1));
        r[b] = ~r[b];
      end
      cycle("rand", r, $urandom_range(19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
